// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file defaults and the zero-register index
package regfile_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 32;
  function automatic int zero_reg_idx();
    return 0;
  endfunction
endpackage

// File: rtl/regfile_bypass_mux.sv
// regfile_bypass_mux: one read port with write-through bypass and zero-register masking
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_WR = 2
) (
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0]        mem_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     hit
);
  logic is_zero;
  assign is_zero = rd_addr == ADDR_W'(zero_reg_idx());
  // later ports overwrite earlier ones, so the highest index wins
  always_comb begin
    rd_data = mem_data;
    hit = 1'b0;
    for (int w = 0; w < NUM_WR; w++)
      if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == rd_addr) begin
        rd_data = wr_data[w*DATA_W +: DATA_W];
        hit = 1'b1;
      end
    rd_data = is_zero ? '0 : rd_data;
    hit = hit && !is_zero;
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port GPR file with fixed-priority writes, bypass and busy scoreboard
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(zero_reg_idx());
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0] busy, clr, busy_nxt;
  assign busy_vec = busy;
  // an issue outranks a same-cycle writeback: the new producer is still outstanding
  always_comb begin
    clr = '0;
    for (int w = 0; w < NUM_WR; w++)
      if (wr_en[w]) clr[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
    busy_nxt = busy & ~clr;
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[ZERO] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
      busy <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] != ZERO)
          mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
      busy <= busy_nxt;
    end
  end
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic hit;
    assign a = rd_addr[p*ADDR_W +: ADDR_W];
    regfile_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_mux (
      .rd_addr(a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .mem_data(mem[a]), .rd_data(d), .hit(hit)
    );
    assign rd_data[p*DATA_W +: DATA_W] = reset ? '0 : d;
    assign rd_busy[p] = !reset && busy[a] && !hit;
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed self-checking bench for regfile_mp_sb
module tb_regfile_mp_sb;
  logic clk = 1'b0, reset = 1'b1;
  logic [9:0] rd_addr = '0, wr_addr = '0;
  logic [63:0] rd_data, wr_data = '0;
  logic [1:0] rd_busy, wr_en = '0;
  logic iss_en = 1'b0;
  logic [4:0] iss_addr = '0;
  logic [31:0] busy_vec;
  int n_checks = 0, n_fail = 0;

  regfile_mp_sb dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    // dirty every register and mark every one busy (issue beats writeback)
    for (int r = 1; r < 32; r++) begin
      iss_en = 1'b1; iss_addr = 5'(r);
      wr_en = 2'b01; wr_addr = {5'd0, 5'(r)}; wr_data = {32'd0, 32'(r * 3 + 1)};
      tick();
    end
    idle();
    rd(5, 0);
    check("dirty_busy_vec", busy_vec, 32'hFFFF_FFFE);
    check("dirty_r5", rd_data[31:0], 32'd16);
    check("dirty_rd_busy", rd_busy, 2'b01);
    // test 1: reset
    reset = 1'b1;
    rd(5, 9);
    check("in_reset_rd_data", rd_data, 64'd0);
    check("in_reset_rd_busy", rd_busy, 2'b00);
    tick();
    reset = 1'b0;
    #1;
    check("post_reset_busy_vec", busy_vec, 32'd0);
    begin
      logic [31:0] nz = '0;
      for (int r = 0; r < 32; r++) begin
        rd(5'(r), 5'(31 - r));
        nz[r] = |rd_data;
      end
      check("post_reset_reads_zero", nz, 32'd0);
    end
    // test 2: same-address double write, highest port wins, bypassed
    wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'h2222, 32'h1111};
    rd(5, 5);
    check("t2_bypass_p0", rd_data[31:0], 32'h2222);
    check("t2_bypass_p1", rd_data[63:32], 32'h2222);
    tick(); idle(); rd(5, 0);
    check("t2_mem", rd_data[31:0], 32'h2222);
    check("t2_r0", rd_data[63:32], 32'h0);
    // distinct addresses on both ports
    wr_en = 2'b11; wr_addr = {5'd11, 5'd10}; wr_data = {32'hBBBB, 32'hAAAA};
    rd(10, 11);
    check("dual_bypass", rd_data, {32'hBBBB, 32'hAAAA});
    tick(); idle(); rd(11, 10);
    check("dual_mem", rd_data, {32'hAAAA, 32'hBBBB});
    // test 3: register 0 ignores writes and issues
    wr_en = 2'b11; wr_addr = '0; wr_data = {32'hDEAD, 32'hDEAD};
    iss_en = 1'b1; iss_addr = 5'd0;
    rd(0, 0);
    check("t3_r0_bypass", rd_data, 64'd0);
    check("t3_r0_rd_busy", rd_busy, 2'b00);
    tick(); idle(); rd(0, 0);
    check("t3_r0_mem", rd_data, 64'd0);
    check("t3_busy_vec", busy_vec, 32'd0);
    // test 4: issue then writeback
    iss_en = 1'b1; iss_addr = 5'd7;
    tick(); idle(); rd(7, 5);
    check("t4_busy_vec", busy_vec, 32'h0000_0080);
    check("t4_rd_busy", rd_busy, 2'b01);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'd0, 32'hCAFE};
    rd(7, 5);
    check("t4_wb_rd_busy", rd_busy, 2'b00);
    check("t4_wb_rd_data", rd_data[31:0], 32'hCAFE);
    tick(); idle(); rd(7, 5);
    check("t4_busy_cleared", busy_vec, 32'd0);
    check("t4_mem", rd_data[31:0], 32'hCAFE);
    // test 5: re-issue with same-cycle writeback keeps the register busy
    iss_en = 1'b1; iss_addr = 5'd9;
    tick(); idle();
    check("t5_busy_set", busy_vec, 32'h0000_0200);
    iss_en = 1'b1; iss_addr = 5'd9;
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h9999, 32'd0};
    rd(9, 9);
    check("t5_bypass", rd_data, {32'h9999, 32'h9999});
    check("t5_rd_busy_wb", rd_busy, 2'b00);
    tick(); idle(); rd(9, 7);
    check("t5_busy_kept", busy_vec, 32'h0000_0200);
    check("t5_rd_busy_after", rd_busy, 2'b01);
    check("t5_mem", rd_data[31:0], 32'h9999);
    // test 6: reset drops a same-cycle issue and write
    reset = 1'b1;
    iss_en = 1'b1; iss_addr = 5'd3;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'h3333};
    rd(3, 9);
    check("t6_in_reset_rd", rd_data, 64'd0);
    tick(); reset = 1'b0; idle(); rd(3, 9);
    check("t6_busy_vec", busy_vec, 32'd0);
    check("t6_mem", rd_data, 64'd0);
    check("t6_rd_busy", rd_busy, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
